// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the FSM's X and Y buttons.
// Each channel: 2-flop synchronizer -> counter debouncer -> rising-edge pulse.
// Channel 0 is X, channel 1 is Y; the channels share no state.
module fsm_input_conditioner #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic X_RAW,
  input  logic Y_RAW,
  output logic X,
  output logic Y,
  output logic X_LVL,
  output logic Y_LVL
);

  // Last count value before a differing level is accepted.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [1:0]            s1_q, s1_d;
  logic [1:0]            s2_q, s2_d;
  logic [1:0]            lvl_q, lvl_d;
  logic [1:0]            pulse_q, pulse_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer chain: only s2 feeds the debouncer.
  always_comb begin
    s1_d = {Y_RAW, X_RAW};
    s2_d = s1_q;
  end

  // Debounce: any agreement between s2 and the accepted level restarts the window.
  always_comb begin
    lvl_d   = lvl_q;
    cnt_d   = '0;
    pulse_d = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] == lvl_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        lvl_d[i]   = s2_q[i];
        // Only a 0->1 acceptance produces a pulse; releases are silent.
        pulse_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // State register; reset clears everything at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q    <= '0;
      s2_q    <= '0;
      lvl_q   <= '0;
      pulse_q <= '0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      lvl_q   <= lvl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign X     = pulse_q[0];
  assign Y     = pulse_q[1];
  assign X_LVL = lvl_q[0];
  assign Y_LVL = lvl_q[1];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Bench for fsm_input_conditioner (DB_CYCLES = 4).
// Expected pulse edge numbers are queued when a raw input is changed and
// popped when the DUT pulses.
module tb_fsm_input_conditioner;

  logic clk;
  logic rst_n;
  logic x_raw;
  logic y_raw;
  logic x, y, x_lvl, y_lvl;

  int n_checks = 0;
  int n_err    = 0;
  int edge_n   = 0;
  int xq[$];
  int yq[$];
  int exp_x_cnt = 0;
  int exp_y_cnt = 0;
  int obs_x_cnt = 0;
  int obs_y_cnt = 0;

  fsm_input_conditioner #(.DB_CYCLES(4)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .X_RAW (x_raw),
    .Y_RAW (y_raw),
    .X     (x),
    .Y     (y),
    .X_LVL (x_lvl),
    .Y_LVL (y_lvl)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Advance n rising edges, then settle 2 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // A raw change made now is first sampled on edge_n+1; acceptance and the
  // pulse land 5 edges later, i.e. visible after edge edge_n+6.
  task automatic push_x();
    xq.push_back(edge_n + 6);
    exp_x_cnt++;
  endtask

  task automatic push_y();
    yq.push_back(edge_n + 6);
    exp_y_cnt++;
  endtask

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (x !== 1'b0) begin
        obs_x_cnt++;
        if (xq.size() == 0) check_val("x_extra_pulse", 1, 0);
        else check_val("x_pulse_edge", edge_n, xq.pop_front());
      end
      if (y !== 1'b0) begin
        obs_y_cnt++;
        if (yq.size() == 0) check_val("y_extra_pulse", 1, 0);
        else check_val("y_pulse_edge", edge_n, yq.pop_front());
      end
    end
  end

  initial begin
    int d;
    rst_n = 1'b0;
    x_raw = 1'b0;
    y_raw = 1'b0;
    step(3);
    check_val("reset_outs", {x, y, x_lvl, y_lvl}, 4'b0000);
    rst_n = 1'b1;
    step(2);

    // Clean press on X, level timing and silent release.
    x_raw = 1'b1;
    push_x();
    step(5);
    check_val("x_lvl_pre_accept", x_lvl, 1'b0);
    step(1);
    check_val("x_lvl_accept", x_lvl, 1'b1);
    check_val("y_lvl_idle", y_lvl, 1'b0);
    step(14);
    x_raw = 1'b0;
    step(5);
    check_val("x_lvl_pre_release", x_lvl, 1'b1);
    step(1);
    check_val("x_lvl_release", x_lvl, 1'b0);
    step(6);

    // Bounce: high 3 cycles is one short of acceptance, then steady high.
    x_raw = 1'b1;
    step(3);
    x_raw = 1'b0;
    step(1);
    x_raw = 1'b1;
    push_x();
    step(12);
    x_raw = 1'b0;
    step(10);
    check_val("bounce_x_lvl_low", x_lvl, 1'b0);

    // Simultaneous press, release, re-press.
    for (int k = 0; k < 2; k++) begin
      x_raw = 1'b1;
      y_raw = 1'b1;
      push_x();
      push_y();
      step(12);
      check_val("simul_lvls_high", {x_lvl, y_lvl}, 2'b11);
      x_raw = 1'b0;
      y_raw = 1'b0;
      step(10);
      check_val("simul_lvls_low", {x_lvl, y_lvl}, 2'b00);
    end

    // X held while Y toggles 8 high / 8 low.
    x_raw = 1'b1;
    push_x();
    for (int k = 0; k < 3; k++) begin
      y_raw = 1'b1;
      push_y();
      step(8);
      check_val("indep_y_lvl_high", y_lvl, 1'b1);
      y_raw = 1'b0;
      step(8);
      check_val("indep_y_lvl_low", y_lvl, 1'b0);
      check_val("indep_x_lvl_held", x_lvl, 1'b1);
    end
    x_raw = 1'b0;
    step(5);
    check_val("indep_x_lvl_pre_drop", x_lvl, 1'b1);
    step(1);
    check_val("indep_x_lvl_drop", x_lvl, 1'b0);
    step(6);

    // Asynchronous reset mid-cycle while both levels are high.
    x_raw = 1'b1;
    y_raw = 1'b1;
    push_x();
    push_y();
    step(10);
    check_val("async_pre_lvls", {x_lvl, y_lvl}, 2'b11);
    #1 rst_n = 1'b0;
    #1 check_val("async_reset_now", {x, y, x_lvl, y_lvl}, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      step(1);
      check_val("async_reset_held", {x, y, x_lvl, y_lvl}, 4'b0000);
    end
    rst_n = 1'b1;
    // Raw inputs still high: they must re-qualify and pulse again.
    push_x();
    push_y();
    step(10);
    x_raw = 1'b0;
    y_raw = 1'b0;
    step(10);

    // Reset in the middle of an X qualification window.
    x_raw = 1'b1;
    step(2);
    rst_n = 1'b0;
    step(2);
    check_val("midq_reset_lvl", x_lvl, 1'b0);
    rst_n = 1'b1;
    push_x();
    step(12);
    x_raw = 1'b0;
    step(10);

    check_val("x_queue_drained", xq.size(), 0);
    check_val("y_queue_drained", yq.size(), 0);
    check_val("x_pulse_count", obs_x_cnt, exp_x_cnt);
    check_val("y_pulse_count", obs_y_cnt, exp_y_cnt);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fsm_input_conditioner.md
Name: fsm_input_conditioner

Overview:
- Conditions the two raw asynchronous button/switch inputs that drive the FSM's X and Y inputs.
- Per channel: 2-flop synchronizer, then counter-based debouncer, then rising-edge detector.
- X and Y outputs are clean single-CLK-cycle pulses, one per accepted press.
- Sits directly upstream of the FSM. Its X/Y outputs connect straight to FSM .X/.Y on the same CLK.

Parameters:
- DB_CYCLES, 4, number of consecutive CLK edges a synchronized input must differ from its debounced level before the new level is accepted. Legal range 1..65535. Use 4 in simulation; board builds use a larger value.
- CNT_W, $clog2(DB_CYCLES+1), debounce counter width. Derived; do not override.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST_N  input  1  asynchronous active-low reset. Asserting it clears all state immediately; deassertion is synchronous to CLK externally.
- X_RAW  input  1  raw asynchronous level from button/switch X.
- Y_RAW  input  1  raw asynchronous level from button/switch Y.
- X  output  1  one-cycle pulse on each accepted 0->1 transition of X_RAW (to FSM.X).
- Y  output  1  one-cycle pulse on each accepted 0->1 transition of Y_RAW (to FSM.Y).
- X_LVL  output  1  debounced level of X_RAW (registered).
- Y_LVL  output  1  debounced level of Y_RAW (registered).

Behaviour:
- Reset (RST_N=0, asynchronous) sets all of the following to 0 and holds them while low:
  - sync flops s1 and s2
  - debounced level S
  - counter C
  - X, Y, X_LVL, Y_LVL
- X and Y channels are identical and fully independent. No arbitration; both may pulse in the same cycle.
- Synchronizer: on each edge, s1 <= RAW and s2 <= s1. No other logic reads s1.
- Debouncer, evaluated each edge:
  - If s2 == S: C <= 0.
  - Else if C == DB_CYCLES-1: S <= s2 and C <= 0.
  - Else: C <= C+1.
  - The same counter applies to both directions (press and release).
- Glitch handling: any edge with s2 == S resets C. A bounce therefore restarts the full DB_CYCLES qualification window.
- Pulse: on the edge where S goes 0->1, X (or Y) <= 1. On every other edge it is <= 0.
  - Pulse width is exactly one CLK cycle.
  - A 1->0 acceptance produces no pulse.
- X_LVL and Y_LVL equal S.
- Latency: RAW rises before edge 0 and stays stable. s2=1 after edge 1. Mismatch is counted on edges 2..DB_CYCLES+1. S and the pulse assert after edge DB_CYCLES+1 and the pulse deasserts after edge DB_CYCLES+2. With DB_CYCLES=4, X is high during the cycle between edges 5 and 6.
- DB_CYCLES=1: S follows s2 one edge later, with no filtering beyond synchronization.
- A held input produces one pulse only. Releasing and re-pressing requires a full accepted release followed by a full accepted press.
- Counter never wraps; its maximum value is DB_CYCLES-1.
- Reset mid-qualification or mid-pulse discards the count and any pulse. After release, a level already high on RAW is re-qualified and produces a new pulse.
- No combinational path from RAW to any output.

Test Plan:
- Reset check: RST_N=0 with X_RAW=Y_RAW=1 applied asynchronously between edges -> X, Y, X_LVL, Y_LVL read 0 immediately and stay 0 while reset is held.
- Clean press, DB_CYCLES=4, 10 ns CLK: X_RAW 0->1 before edge 0 and held 200 ns -> X=1 for exactly one cycle after edge 5. X_LVL=1 from edge 5 onward. Y stays 0.
- Bounce rejection: X_RAW high 3 cycles, low 1 cycle, then high steady -> no pulse during the bounce. A single X pulse appears 5 edges after the final rise. Total pulse count is 1.
- Simultaneous press: X_RAW and Y_RAW rise together and are held -> X and Y pulse in the same cycle, once each. Release both for 10 cycles, re-press -> exactly one more pulse each.
- Independence and release: X_RAW held high while Y_RAW toggles with 8-cycle high/8-cycle low periods -> X pulses once. Y pulses once per Y high period. X_LVL drops 5 edges after X_RAW falls, with no X pulse on release.
- Reset mid-operation: assert RST_N low 2 cycles after a pulse-qualifying X_RAW rise, release 2 cycles later with X_RAW still high -> no pulse before reset. One X pulse occurs 5 edges after the first edge following RST_N deassertion.
